avalon_master_ctrl: RTL and testbench
=====================================

Name: avalon_master_ctrl

Overview:
- Avalon-MM master bus engine that sits directly downstream of the control-unit state machine.
- Accepts single-beat read/write requests (n_action, rdwr_cntl) with a pre-muxed address and write data, and runs the Avalon-MM handshake including waitrequest and readdatavalid.
- Reports completion on idle_out and read completion on read_state, which are the signals the control unit waits on.
- A timeout guarantees the control unit can never deadlock on a dead slave.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, maximum cycles spent in an issue/wait state before the transaction is aborted.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  asynchronous active-low reset.
- n_action  in  1  active-low request strobe; sampled only in IDLE.
- rdwr_cntl  in  1  1 = write, 0 = read; sampled with n_action.
- address_in  in  ADDR_W  transaction address; sampled with n_action.
- data_in  in  DATA_W  write data; sampled with n_action.
- avm_address  out  ADDR_W  registered bus address.
- avm_read  out  1  bus read request.
- avm_write  out  1  bus write request.
- avm_writedata  out  DATA_W  registered write data.
- avm_byteenable  out  DATA_W/8  constant all-ones.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  DATA_W  slave read data.
- avm_readdatavalid  in  1  read data qualifier.
- data_out  out  DATA_W  last captured read data.
- idle_out  out  1  high only in IDLE.
- read_state  out  1  one-cycle pulse when a read completes.
- timeout_err  out  1  set by an aborted transaction; cleared by the next accepted request.

Behaviour:
- Reset values (asynchronous, on n_rst low):
  - state = IDLE, idle_out = 1.
  - avm_read = avm_write = 0.
  - avm_address = 0, avm_writedata = 0, data_out = 0.
  - read_state = 0, timeout_err = 0, timeout counter = 0.
- States: IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT, DONE. All outputs other than data_out/avm_address/avm_writedata/timeout_err decode from the registered state.
- IDLE:
  - idle_out = 1.
  - If n_action == 0 at a rising edge: register address_in, data_in and rdwr_cntl; clear timeout_err and the counter.
  - Go to WR_ISSUE if rdwr_cntl = 1, else RD_ISSUE.
- WR_ISSUE:
  - avm_write = 1; address and data held stable.
  - If avm_waitrequest = 0, the write is accepted: go to DONE.
- RD_ISSUE:
  - avm_read = 1.
  - On accept (avm_waitrequest = 0): go to RD_WAIT.
  - If avm_readdatavalid = 1 in the same accept cycle: capture data_out and go directly to DONE.
- RD_WAIT:
  - avm_read = 0.
  - On avm_readdatavalid = 1: data_out <= avm_readdata, go to DONE.
- DONE:
  - idle_out = 0.
  - read_state = 1 if the completed transaction was a read (including a timed-out read).
  - Next state is always IDLE.
- Timeout:
  - Counter increments every cycle in WR_ISSUE, RD_ISSUE and RD_WAIT, and resets on each state entry.
  - If the counter reaches TIMEOUT and the exit condition is not met: drop avm_read/avm_write, set timeout_err, go to DONE.
  - On a read timeout, data_out <= 0.
- Latency, zero-wait write: request edge E; WR_ISSUE in cycle E+1; DONE in E+2; idle_out = 1 from E+3.
- Latency, read: read_state pulses one cycle after the readdatavalid cycle.
- Control-unit timing: idle_out falls in the cycle right after the request edge, so a one-cycle REQ state followed by a wait-for-idle_out state is safe.
- Boundaries:
  - n_action while not IDLE is ignored; no queuing.
  - avm_readdatavalid outside RD_ISSUE/RD_WAIT is ignored.
  - data_out changes only on read completion.
  - Reset mid-transaction drops avm_read/avm_write immediately and forces IDLE; a late readdatavalid after reset is ignored.
  - Counter width is $clog2(TIMEOUT+1) and it must never wrap.

Test Plan:
- Write, waitrequest low: n_action=0, rdwr=1, addr=0x4, data=0xDEADBEEF -> avm_write high exactly 1 cycle with addr 0x4 and data 0xDEADBEEF; idle_out 0 for 2 cycles, then 1.
- Write, waitrequest held 3 cycles -> avm_write high 4 cycles with address/data stable; one DONE cycle; timeout_err = 0.
- Read, accept immediately, readdatavalid 2 cycles later with 0x53 -> data_out = 0x53; read_state one pulse; avm_read high exactly 1 cycle.
- Read, same-cycle accept and readdatavalid with 0x11 -> RD_WAIT skipped; read_state pulses 2 cycles after the request edge.
- TIMEOUT=8, read never valid -> abort after 8 RD_WAIT cycles; timeout_err = 1, data_out = 0, read_state pulses; next request clears timeout_err.
- n_action=0 pulses during WR_ISSUE ignored; n_rst low during RD_WAIT -> avm_read = 0, idle_out = 1, outputs at reset values; stray readdatavalid afterwards ignored.

Source files
------------

// File: rtl/avalon_master_ctrl.sv
// rtl/avalon_master_ctrl.sv - single-beat Avalon-MM master engine with waitrequest/readdatavalid and timeout
`timescale 1ns/1ps
module avalon_master_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                n_action,
  input  logic                rdwr_cntl,
  input  logic [ADDR_W-1:0]   address_in,
  input  logic [DATA_W-1:0]   data_in,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic                avm_waitrequest,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_readdatavalid,
  output logic [DATA_W-1:0]   data_out,
  output logic                idle_out,
  output logic                read_state,
  output logic                timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ISSUE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_address;
  logic [DATA_W-1:0]   r_writedata;
  logic [DATA_W-1:0]   r_data_out;
  logic                r_is_read;
  logic                r_timeout_err;
  logic                w_expired;
  logic                w_accept;
  logic                w_rd_done;
  logic                w_abort;
  logic                w_busy;

  // Abort fires on the TIMEOUT-th cycle of a stalled state, so the counter tops out below TIMEOUT.
  assign w_expired = (r_cnt >= CNT_W'(TIMEOUT - 1));
  assign w_accept  = (r_state == S_IDLE) && !n_action;
  assign w_busy    = (r_state == S_WR_ISSUE) || (r_state == S_RD_ISSUE) || (r_state == S_RD_WAIT);
  assign w_rd_done = avm_readdatavalid &&
                     (((r_state == S_RD_ISSUE) && !avm_waitrequest) || (r_state == S_RD_WAIT));

  always_comb begin
    w_next  = r_state;
    w_abort = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!n_action) w_next = rdwr_cntl ? S_WR_ISSUE : S_RD_ISSUE;
      end
      S_WR_ISSUE: begin
        if (!avm_waitrequest) begin
          w_next = S_DONE;
        end else if (w_expired) begin
          w_next  = S_DONE;
          w_abort = 1'b1;
        end
      end
      S_RD_ISSUE: begin
        if (!avm_waitrequest) begin
          w_next = avm_readdatavalid ? S_DONE : S_RD_WAIT;
        end else if (w_expired) begin
          w_next  = S_DONE;
          w_abort = 1'b1;
        end
      end
      S_RD_WAIT: begin
        if (avm_readdatavalid) begin
          w_next = S_DONE;
        end else if (w_expired) begin
          w_next  = S_DONE;
          w_abort = 1'b1;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_address     <= '0;
      r_writedata   <= '0;
      r_data_out    <= '0;
      r_is_read     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (!w_busy || (w_next != r_state)) begin
        r_cnt <= '0;
      end else if (!w_expired) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_accept) begin
        r_address     <= address_in;
        r_writedata   <= data_in;
        r_is_read     <= !rdwr_cntl;
        r_timeout_err <= 1'b0;
      end
      if (w_abort) r_timeout_err <= 1'b1;
      if (w_rd_done) begin
        r_data_out <= avm_readdata;
      end else if (w_abort && r_is_read) begin
        r_data_out <= '0;
      end
    end
  end

  assign avm_address    = r_address;
  assign avm_writedata  = r_writedata;
  assign avm_byteenable = '1;
  assign avm_write      = (r_state == S_WR_ISSUE);
  assign avm_read       = (r_state == S_RD_ISSUE);
  assign idle_out       = (r_state == S_IDLE);
  assign read_state     = (r_state == S_DONE) && r_is_read;
  assign data_out       = r_data_out;
  assign timeout_err    = r_timeout_err;

endmodule

// File: tb/tb_avalon_master_ctrl.sv
// tb/tb_avalon_master_ctrl.sv - directed scoreboard bench for avalon_master_ctrl
`timescale 1ns/1ps
module tb_avalon_master_ctrl;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        n_action;
  logic        rdwr_cntl;
  logic [31:0] address_in;
  logic [31:0] data_in;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic [31:0] data_out;
  logic        idle_out;
  logic        read_state;
  logic        timeout_err;

  int n_checks = 0;
  int n_errors = 0;
  int wr_cycles = 0;
  int rd_cycles = 0;
  int rs_pulses = 0;
  logic [63:0] wr_q[$];
  logic [31:0] rd_q[$];

  avalon_master_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .n_rst(n_rst), .n_action(n_action), .rdwr_cntl(rdwr_cntl),
    .address_in(address_in), .data_in(data_in),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .data_out(data_out),
    .idle_out(idle_out), .read_state(read_state), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic wr, input logic [31:0] a, input logic [31:0] d);
    n_action   = 1'b0;
    rdwr_cntl  = wr;
    address_in = a;
    data_in    = d;
    nxt();
    n_action   = 1'b1;
  endtask

  // Scoreboard side: accepted writes and completed reads are popped and compared here.
  always @(negedge clk) begin
    if (n_rst) begin
      if (avm_write) wr_cycles++;
      if (avm_read) rd_cycles++;
      if (avm_write && !avm_waitrequest) begin
        if (wr_q.size() == 0) check("wr_unexpected", {avm_address, avm_writedata}, 64'hx);
        else check("wr_beat", {avm_address, avm_writedata}, wr_q.pop_front());
      end
      if (read_state) begin
        rs_pulses++;
        if (rd_q.size() == 0) check("rd_unexpected", {32'h0, data_out}, 64'hx);
        else check("rd_data", {32'h0, data_out}, {32'h0, rd_q.pop_front()});
      end
    end
  end

  initial begin
    n_rst = 1'b0; n_action = 1'b1; rdwr_cntl = 1'b0; address_in = '0; data_in = '0;
    avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0;
    nxt(); nxt();
    check("rst_idle", {63'h0, idle_out}, 64'h1);
    check("rst_rdwr", {62'h0, avm_read, avm_write}, 64'h0);
    check("rst_addr_data", {avm_address, avm_writedata}, 64'h0);
    check("rst_dout_flags", {data_out, 30'h0, read_state, timeout_err}, 64'h0);
    check("byteenable", {60'h0, avm_byteenable}, 64'hF);
    n_rst = 1'b1;
    nxt();

    // Zero-wait write
    wr_cycles = 0;
    wr_q.push_back({32'h4, 32'hDEADBEEF});
    request(1'b1, 32'h4, 32'hDEADBEEF);
    check("w0_e1", {62'h0, avm_write, idle_out}, 64'h2);
    check("w0_beat", {avm_address, avm_writedata}, {32'h4, 32'hDEADBEEF});
    nxt();
    check("w0_done", {62'h0, avm_write, idle_out}, 64'h0);
    nxt();
    check("w0_idle", {63'h0, idle_out}, 64'h1);
    check("w0_cycles", wr_cycles, 1);

    // Write stalled 3 cycles, with an ignored request pulse mid-stall
    wr_cycles = 0;
    avm_waitrequest = 1'b1;
    wr_q.push_back({32'h8, 32'h12345678});
    request(1'b1, 32'h8, 32'h12345678);
    for (int i = 0; i < 3; i++) begin
      check("w1_stall", {avm_write, 31'h0, avm_address}, {1'b1, 31'h0, 32'h8});
      n_action   = (i == 1) ? 1'b0 : 1'b1;
      address_in = 32'hBAD0;
      nxt();
    end
    n_action = 1'b1;
    avm_waitrequest = 1'b0;
    check("w1_last", {avm_write, 31'h0, avm_writedata}, {1'b1, 31'h0, 32'h12345678});
    nxt();
    check("w1_done", {61'h0, avm_write, idle_out, timeout_err}, 64'h0);
    nxt();
    check("w1_idle", {idle_out, 31'h0, avm_address}, {1'b1, 31'h0, 32'h8});
    check("w1_cycles", wr_cycles, 4);

    // Read: accept immediately, data valid two cycles after accept
    rd_cycles = 0; rs_pulses = 0;
    rd_q.push_back(32'h53);
    request(1'b0, 32'h20, 32'h0);
    check("r0_issue", {62'h0, avm_read, idle_out}, 64'h2);
    nxt();
    check("r0_wait", {61'h0, avm_read, idle_out, read_state}, 64'h0);
    nxt();
    avm_readdatavalid = 1'b1; avm_readdata = 32'h53;
    nxt();
    avm_readdatavalid = 1'b0; avm_readdata = 32'h0;
    check("r0_done", {read_state, 31'h0, data_out}, {1'b1, 31'h0, 32'h53});
    nxt();
    check("r0_idle", {62'h0, read_state, idle_out}, 64'h1);
    check("r0_counts", {rd_cycles[31:0], rs_pulses[31:0]}, {32'd1, 32'd1});

    // Read: accept and readdatavalid in the same cycle
    rd_q.push_back(32'h11);
    request(1'b0, 32'h30, 32'h0);
    avm_readdatavalid = 1'b1; avm_readdata = 32'h11;
    nxt();
    avm_readdatavalid = 1'b0; avm_readdata = 32'h0;
    check("r1_done_e2", {read_state, 31'h0, data_out}, {1'b1, 31'h0, 32'h11});
    nxt();
    check("r1_idle", {63'h0, idle_out}, 64'h1);
    avm_readdatavalid = 1'b1; avm_readdata = 32'hFF;
    nxt();
    avm_readdatavalid = 1'b0;
    nxt();
    check("stray_valid_idle", {31'h0, read_state, data_out}, {32'h0, 32'h11});

    // Read timeout: accepted but data never returns
    rd_q.push_back(32'h0);
    request(1'b0, 32'h40, 32'h0);
    nxt();
    for (int k = 0; k < 8; k++) begin
      check("to_wait", {61'h0, read_state, idle_out, avm_read}, 64'h0);
      nxt();
    end
    check("to_done", {read_state, timeout_err, 30'h0, data_out}, {2'b11, 62'h0});
    nxt();
    check("to_sticky", {62'h0, idle_out, timeout_err}, 64'h3);
    wr_q.push_back({32'h50, 32'hCAFE});
    request(1'b1, 32'h50, 32'hCAFE);
    check("to_clear", {62'h0, avm_write, timeout_err}, 64'h2);
    nxt(); nxt();

    // Reset in the middle of RD_WAIT, then a late readdatavalid
    request(1'b0, 32'h60, 32'h0);
    nxt();
    check("rst_mid_pre", {62'h0, avm_read, idle_out}, 64'h0);
    #2;
    n_rst = 1'b0;
    #1;
    check("rst_mid", {avm_read, avm_write, idle_out, timeout_err, 28'h0, avm_address}, {4'b0010, 60'h0});
    check("rst_mid_data", {avm_writedata, data_out}, 64'h0);
    avm_readdatavalid = 1'b1; avm_readdata = 32'hAA;
    nxt();
    n_rst = 1'b1;
    nxt(); nxt();
    avm_readdatavalid = 1'b0;
    check("late_valid", {30'h0, read_state, idle_out, data_out}, {32'h1, 32'h0});

    check("queues_empty", {32'(wr_q.size()), 32'(rd_q.size())}, 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #50000;
    n_errors++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
